// File: rtl/ibex_wb_stage_p.sv
// Writeback stage with a single-entry holding register. It completes ALU results directly and
// retires load/store entries on the LSU response. Also holds the optional sticky vxsat flag.
package ibex_pkg;
    typedef enum logic [1:0] {
        RV32PNone,
        RV32PZpn,
        RV32PFull
    } rv32p_e;
endpackage

module ibex_wb_stage_p #(
    parameter ibex_pkg::rv32p_e RV32P = ibex_pkg::RV32PNone
) (
    input  logic        clk_i,
    input  logic        rst_i,

    input  logic        en_wb_i,
    input  logic [1:0]  instr_type_wb_i,
    input  logic [31:0] pc_id_i,
    input  logic [4:0]  rf_waddr_id_i,
    input  logic        rf_we_id_i,
    input  logic [31:0] rf_wdata_id_i,
    input  logic        set_ov_i,

    input  logic        lsu_resp_valid_i,
    input  logic        lsu_resp_err_i,
    input  logic [31:0] rf_wdata_lsu_i,

    input  logic        vxsat_we_i,
    input  logic        vxsat_wdata_i,

    output logic        ready_wb_o,
    output logic        rf_we_wb_o,
    output logic [4:0]  rf_waddr_wb_o,
    output logic [31:0] rf_wdata_wb_o,
    output logic [31:0] pc_wb_o,
    output logic        instr_done_wb_o,
    output logic        outstanding_load_wb_o,
    output logic        outstanding_store_wb_o,
    output logic        lsu_err_wb_o,
    output logic        vxsat_o
);

    typedef enum logic [1:0] {
        TypeOther = 2'd0,
        TypeLoad  = 2'd1,
        TypeStore = 2'd2
    } wb_type_e;

    logic        wb_valid_q;
    wb_type_e    type_q;
    logic [31:0] pc_q;
    logic [4:0]  waddr_q;
    logic        we_q;
    logic [31:0] wdata_q;
    logic        set_ov_q;

    logic        wb_done;
    logic        accept;
    logic        is_other;
    logic        is_load;
    logic        is_store;
    wb_type_e    type_in;

    assign is_other = (type_q == TypeOther);
    assign is_load  = (type_q == TypeLoad);
    assign is_store = (type_q == TypeStore);

    // Encoding 3 is folded into OTHER at capture so the held type is always legal.
    always_comb begin
        unique case (instr_type_wb_i)
            2'd1:    type_in = TypeLoad;
            2'd2:    type_in = TypeStore;
            default: type_in = TypeOther;
        endcase
    end

    assign wb_done    = wb_valid_q && (is_other || lsu_resp_valid_i);
    assign ready_wb_o = !wb_valid_q || wb_done;
    assign accept     = en_wb_i && ready_wb_o;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wb_valid_q <= 1'b0;
            type_q     <= TypeOther;
            pc_q       <= 32'h0;
            waddr_q    <= 5'h0;
            we_q       <= 1'b0;
            wdata_q    <= 32'h0;
            set_ov_q   <= 1'b0;
        end else begin
            if (accept) begin
                wb_valid_q <= 1'b1;
                type_q     <= type_in;
                pc_q       <= pc_id_i;
                waddr_q    <= rf_waddr_id_i;
                we_q       <= rf_we_id_i;
                wdata_q    <= rf_wdata_id_i;
                set_ov_q   <= set_ov_i;
            end else if (wb_done) begin
                wb_valid_q <= 1'b0;
            end
        end
    end

    always_comb begin
        rf_we_wb_o    = wb_done && we_q && (is_other || (is_load && !lsu_resp_err_i));
        rf_wdata_wb_o = 32'h0;
        if (rf_we_wb_o) begin
            rf_wdata_wb_o = is_load ? rf_wdata_lsu_i : wdata_q;
        end
    end

    assign rf_waddr_wb_o          = waddr_q;
    assign pc_wb_o                = pc_q;
    assign instr_done_wb_o        = wb_done;
    assign outstanding_load_wb_o  = wb_valid_q && is_load;
    assign outstanding_store_wb_o = wb_valid_q && is_store;
    assign lsu_err_wb_o           = wb_done && !is_other && lsu_resp_err_i;

    generate
        if (RV32P != ibex_pkg::RV32PNone) begin : g_vxsat
            logic vxsat_q;
            logic vxsat_d;

            // A saturating retire wins over a same-cycle CSR clear.
            assign vxsat_d = (vxsat_we_i ? vxsat_wdata_i : vxsat_q) |
                             (wb_done && is_other && set_ov_q);

            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    vxsat_q <= 1'b0;
                end else begin
                    vxsat_q <= vxsat_d;
                end
            end

            assign vxsat_o = vxsat_q;
        end else begin : g_no_vxsat
            logic unused_vxsat;
            assign unused_vxsat = set_ov_q ^ vxsat_we_i ^ vxsat_wdata_i;
            assign vxsat_o      = 1'b0;
        end
    endgenerate

endmodule

// File: tb/tb_ibex_wb_stage_p.sv
// Self-checking bench for ibex_wb_stage_p: directed scenarios followed by random traffic,
// all compared against a slot-level behavioural model of the writeback stage.
module tb_ibex_wb_stage_p;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [1:0]  ty;
    logic [31:0] pc;
    logic [4:0]  waddr;
    logic        we;
    logic [31:0] wdata;
    logic        ov;
    logic        rv;
    logic        err;
    logic [31:0] ldata;
    logic        vwe;
    logic        vwd;

    logic        ready;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [31:0] pc_wb;
    logic        done;
    logic        out_ld;
    logic        out_st;
    logic        lsu_err;
    logic        vxsat;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    ibex_wb_stage_p #(
        .RV32P(ibex_pkg::RV32PFull)
    ) dut (
        .clk_i                 (clk),
        .rst_i                 (rst),
        .en_wb_i               (en),
        .instr_type_wb_i       (ty),
        .pc_id_i               (pc),
        .rf_waddr_id_i         (waddr),
        .rf_we_id_i            (we),
        .rf_wdata_id_i         (wdata),
        .set_ov_i              (ov),
        .lsu_resp_valid_i      (rv),
        .lsu_resp_err_i        (err),
        .rf_wdata_lsu_i        (ldata),
        .vxsat_we_i            (vwe),
        .vxsat_wdata_i         (vwd),
        .ready_wb_o            (ready),
        .rf_we_wb_o            (rf_we),
        .rf_waddr_wb_o         (rf_waddr),
        .rf_wdata_wb_o         (rf_wdata),
        .pc_wb_o               (pc_wb),
        .instr_done_wb_o       (done),
        .outstanding_load_wb_o (out_ld),
        .outstanding_store_wb_o(out_st),
        .lsu_err_wb_o          (lsu_err),
        .vxsat_o               (vxsat)
    );

    // Model: one slot holding the instruction in WB (kind: 0 alu, 1 load, 2 store), plus vxsat.
    bit          m_full;
    int          m_kind;
    logic [31:0] m_pc;
    logic [4:0]  m_waddr;
    bit          m_we;
    logic [31:0] m_wdata;
    bit          m_ov;
    bit          m_vx;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    endtask

    task automatic model_clear();
        m_full = 0; m_kind = 0; m_pc = 0; m_waddr = 0; m_we = 0; m_wdata = 0; m_ov = 0; m_vx = 0;
    endtask

    function automatic bit retiring();
        if (!m_full) return 0;
        return (m_kind == 0) || rv;
    endfunction

    task automatic check_all();
        bit          fin;
        bit          wr;
        logic [31:0] wd;
        fin = retiring();
        wr  = 0;
        wd  = 32'h0;
        if (fin) begin
            if (m_kind == 0) wr = m_we;
            else if (m_kind == 1) wr = m_we && !err;
        end
        if (wr) wd = (m_kind == 1) ? ldata : m_wdata;
        check("ready", ready, !m_full || fin);
        check("rf_we", rf_we, wr);
        check("rf_wdata", rf_wdata, wd);
        check("rf_waddr", rf_waddr, m_waddr);
        check("pc_wb", pc_wb, m_pc);
        check("instr_done", done, fin);
        check("out_load", out_ld, m_full && m_kind == 1);
        check("out_store", out_st, m_full && m_kind == 2);
        check("lsu_err", lsu_err, fin && m_kind != 0 && err);
        check("vxsat", vxsat, m_vx);
    endtask

    // Checks outputs mid-cycle, then advances one clock and updates the model.
    task automatic step();
        bit fin;
        bit sat;
        if (rst) model_clear();
        #1;
        check_all();
        @(posedge clk);
        if (rst) begin
            model_clear();
        end else begin
            fin = retiring();
            sat = fin && m_kind == 0 && m_ov;
            m_vx = (vwe ? vwd : m_vx) | sat;
            if (en && (!m_full || fin)) begin
                m_full  = 1;
                m_kind  = (ty == 2'd1) ? 1 : (ty == 2'd2) ? 2 : 0;
                m_pc    = pc;
                m_waddr = waddr;
                m_we    = we;
                m_wdata = wdata;
                m_ov    = ov;
            end else if (fin) begin
                m_full = 0;
            end
        end
        #1;
    endtask

    task automatic idle();
        en = 0; ty = 0; pc = 0; waddr = 0; we = 0; wdata = 0; ov = 0;
        rv = 0; err = 0; ldata = 0; vwe = 0; vwd = 0;
    endtask

    task automatic issue(input logic [1:0] t, input logic [4:0] a, input logic [31:0] d,
                         input logic w, input logic o);
        idle();
        en = 1; ty = t; waddr = a; wdata = d; we = w; ov = o; pc = $urandom;
    endtask

    initial begin
        rst = 1;
        idle();
        model_clear();
        step();
        check("rst_ready", ready, 1);
        step();
        rst = 0;
        step();

        // ALU write
        issue(2'd0, 5'd5, 32'hDEADBEEF, 1, 0);
        step();
        idle();
        #1;
        check("alu_we", rf_we, 1);
        check("alu_waddr", rf_waddr, 5);
        check("alu_wdata", rf_wdata, 32'hDEADBEEF);
        check("alu_done", done, 1);
        step();

        // Back-to-back ALU
        for (int i = 0; i < 3; i++) begin
            issue(2'd0, 5'(i + 1), $urandom, 1, 0);
            #1;
            check("b2b_ready", ready, 1);
            if (i > 0) check("b2b_done", done, 1);
            step();
        end
        idle();
        #1;
        check("b2b_done_last", done, 1);
        step();

        // Load stall
        issue(2'd1, 5'd3, 32'h0, 1, 0);
        step();
        idle();
        for (int i = 0; i < 4; i++) begin
            #1;
            check("ld_ready", ready, 0);
            check("ld_outst", out_ld, 1);
            step();
        end
        rv = 1; ldata = 32'h12345678;
        #1;
        check("ld_we", rf_we, 1);
        check("ld_wdata", rf_wdata, 32'h12345678);
        step();
        idle();

        // Load error
        issue(2'd1, 5'd7, 32'h0, 1, 0);
        step();
        idle();
        rv = 1; err = 1; ldata = 32'hCAFEF00D;
        #1;
        check("lderr_err", lsu_err, 1);
        check("lderr_done", done, 1);
        check("lderr_we", rf_we, 0);
        step();
        idle();

        // Store
        issue(2'd2, 5'd9, 32'h55AA55AA, 1, 0);
        step();
        idle();
        for (int i = 0; i < 2; i++) begin
            #1;
            check("st_outst", out_st, 1);
            check("st_we", rf_we, 0);
            step();
        end
        rv = 1;
        #1;
        check("st_we_resp", rf_we, 0);
        step();
        idle();
        #1;
        check("st_outst_end", out_st, 0);
        step();

        // vxsat: saturation beats same-cycle CSR clear, then a lone clear drops it
        issue(2'd0, 5'd1, 32'h1, 1, 1);
        step();
        idle();
        vwe = 1; vwd = 0;
        step();
        idle();
        #1;
        check("vx_set", vxsat, 1);
        step();
        vwe = 1; vwd = 0;
        step();
        idle();
        #1;
        check("vx_clr", vxsat, 0);
        step();

        // Reset during an outstanding load, then a stray response
        issue(2'd1, 5'd4, 32'h0, 1, 0);
        step();
        idle();
        step();
        rst = 1;
        #1;
        check("rst_mid_ready", ready, 1);
        check("rst_mid_ld", out_ld, 0);
        check("rst_mid_pc", pc_wb, 0);
        step();
        rst = 0;
        rv = 1; ldata = 32'hBAD0BAD0;
        #1;
        check("stray_we", rf_we, 0);
        check("stray_done", done, 0);
        step();
        idle();

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            en    = ($urandom_range(0, 3) != 0);
            ty    = 2'($urandom_range(0, 3));
            pc    = $urandom;
            waddr = 5'($urandom);
            we    = $urandom_range(0, 1);
            wdata = $urandom;
            ov    = ($urandom_range(0, 3) == 0);
            rv    = ($urandom_range(0, 9) < 4);
            err   = ($urandom_range(0, 4) == 0);
            ldata = $urandom;
            vwe   = ($urandom_range(0, 9) == 0);
            vwd   = $urandom_range(0, 1);
            rst   = ($urandom_range(0, 59) == 0);
            step();
        end
        rst = 0;
        idle();
        step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
